// File: rtl/cache_repl_ctrl.sv
// ---------------------------------------------------------------------------
// cache_repl_ctrl
//
// Purpose:
//   Per-cache control FSM. It sequences the tag check, victim selection,
//   dirty-line writeback and line refill for one outstanding CPU request.
//   It owns the write side of the per-set LRU array: it drives mru/index/load
//   and uses the array's lru_out as the replacement victim. The tag, data,
//   valid and dirty arrays live in the datapath and only see strobes from here.
//
// Ports:
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   cpu_read/cpu_write  CPU request, held until cpu_resp (both = write)
//   cpu_index           set index of the request
//   cpu_resp            one-cycle completion pulse
//   hit, hit_way        datapath tag compare result
//   victim_dirty        dirty bit of the way currently offered as victim
//   lru_way             lru_out of the LRU array for cpu_index
//   lru_load/lru_mru/lru_index  LRU array update controls
//   victim_way          latched victim way
//   data_we             CPU write into hit_way (sets dirty)
//   fill_we             refill of victim_way (loads line/tag/valid, clears dirty)
//   mem_read/mem_write  cacheline memory requests, mem_resp completes them
//   hit_count/miss_count  performance counters
//
// Configuration:
//   CACHE_REPL_PERF_CNT_EN  when defined, hit_count/miss_count are saturating
//                           32-bit counters; otherwise both are tied to 0.
// ---------------------------------------------------------------------------
module cache_repl_ctrl #(
    parameter int SET           = 8,
    parameter int ASSOCIATIVITY = 4,
    parameter int LRU_WIDTH     = $clog2(ASSOCIATIVITY),
    parameter int IDX_WIDTH     = $clog2(SET)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [IDX_WIDTH-1:0] cpu_index,
    output logic                 cpu_resp,
    input  logic                 hit,
    input  logic [LRU_WIDTH-1:0] hit_way,
    input  logic                 victim_dirty,
    input  logic [LRU_WIDTH-1:0] lru_way,
    output logic                 lru_load,
    output logic [LRU_WIDTH-1:0] lru_mru,
    output logic [IDX_WIDTH-1:0] lru_index,
    output logic [LRU_WIDTH-1:0] victim_way,
    output logic                 data_we,
    output logic                 fill_we,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic                 mem_resp,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_CHECK     = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_FILL      = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [LRU_WIDTH-1:0] r_victim_way;
    logic                 w_check_hit;
    logic                 w_check_miss;
    logic                 w_fill_done;

    assign w_check_hit  = (r_state == S_CHECK) && hit;
    assign w_check_miss = (r_state == S_CHECK) && !hit;
    assign w_fill_done  = (r_state == S_FILL) && mem_resp;

    // All strobes are decoded from the registered state, so an asynchronous
    // reset removes every memory request and array strobe at once.
    assign cpu_resp   = w_check_hit;
    assign lru_load   = w_check_hit;
    assign lru_mru    = w_check_hit ? hit_way : '0;
    assign data_we    = w_check_hit && cpu_write;
    assign fill_we    = w_fill_done;
    assign mem_read   = (r_state == S_FILL);
    assign mem_write  = (r_state == S_WRITEBACK);
    assign lru_index  = cpu_index;
    assign victim_way = r_victim_way;

    // A simultaneous read+write needs no special routing: data_we already
    // follows cpu_write, so the request behaves as a write.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (cpu_read || cpu_write) w_next_state = S_CHECK;
            S_CHECK:     if (hit)                   w_next_state = S_IDLE;
                         else if (victim_dirty)     w_next_state = S_WRITEBACK;
                         else                       w_next_state = S_FILL;
            S_WRITEBACK: if (mem_resp)              w_next_state = S_FILL;
            S_FILL:      if (mem_resp)              w_next_state = S_CHECK;
            default:                                w_next_state = S_IDLE;
        endcase
    end

    // The victim is captured on the miss edge so that writeback and fill
    // keep targeting the same way even if lru_way changes afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_victim_way <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_check_miss) begin
                r_victim_way <= lru_way;
            end
        end
    end

`ifdef CACHE_REPL_PERF_CNT_EN
    logic        r_refill;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // r_refill marks the CHECK that follows a fill, whose hit belongs to
    // the already-counted miss rather than to a new hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refill     <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_fill_done) begin
                r_refill <= 1'b1;
            end else if (w_check_hit) begin
                r_refill <= 1'b0;
            end
            if (w_check_hit && !r_refill && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_check_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_cache_repl_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_repl_ctrl
//
// Purpose:
//   Self-checking bench for cache_repl_ctrl. Hit transactions come from a
//   table of records; misses, writeback, reset abort and the spurious
//   mem_resp case are hand-written sequences. Counter expectations come
//   from a small model of which CHECK cycles count as hits or misses.
// ---------------------------------------------------------------------------
module tb_cache_repl_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cpu_read;
    logic        cpu_write;
    logic [2:0]  cpu_index;
    logic        cpu_resp;
    logic        hit;
    logic [1:0]  hit_way;
    logic        victim_dirty;
    logic [1:0]  lru_way;
    logic        lru_load;
    logic [1:0]  lru_mru;
    logic [2:0]  lru_index;
    logic [1:0]  victim_way;
    logic        data_we;
    logic        fill_we;
    logic        mem_read;
    logic        mem_write;
    logic        mem_resp;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int testsRun;
    int testsFailed;
    int expHits;
    int expMisses;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [2:0] idx;
        logic [1:0] way;
        logic       expDataWe;
    } hitVec_t;

    hitVec_t hitTable [5];

    cache_repl_ctrl #(.SET(8), .ASSOCIATIVITY(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_index    (cpu_index),
        .cpu_resp     (cpu_resp),
        .hit          (hit),
        .hit_way      (hit_way),
        .victim_dirty (victim_dirty),
        .lru_way      (lru_way),
        .lru_load     (lru_load),
        .lru_mru      (lru_mru),
        .lru_index    (lru_index),
        .victim_way   (victim_way),
        .data_we      (data_we),
        .fill_we      (fill_we),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_resp     (mem_resp),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    // and outputs are sampled 1ns later, well away from either edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] idx,
                                 input logic h, input logic [1:0] hw,
                                 input logic vd, input logic [1:0] lw, input logic mr);
        cpu_read     = rd;
        cpu_write    = wr;
        cpu_index    = idx;
        hit          = h;
        hit_way      = hw;
        victim_dirty = vd;
        lru_way      = lw;
        mem_resp     = mr;
    endtask

    task automatic checkIdleQuiet(input string tag);
        checkOutput({tag, "_resp"},   {31'd0, cpu_resp},  32'd0);
        checkOutput({tag, "_load"},   {31'd0, lru_load},  32'd0);
        checkOutput({tag, "_fillwe"}, {31'd0, fill_we},   32'd0);
        checkOutput({tag, "_memrd"},  {31'd0, mem_read},  32'd0);
        checkOutput({tag, "_memwr"},  {31'd0, mem_write}, 32'd0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        expHits     = 0;
        expMisses   = 0;

        hitTable[0] = '{rd: 1'b1, wr: 1'b0, idx: 3'd3, way: 2'd2, expDataWe: 1'b0};
        hitTable[1] = '{rd: 1'b0, wr: 1'b1, idx: 3'd7, way: 2'd0, expDataWe: 1'b1};
        hitTable[2] = '{rd: 1'b1, wr: 1'b1, idx: 3'd1, way: 2'd3, expDataWe: 1'b1};
        hitTable[3] = '{rd: 1'b1, wr: 1'b0, idx: 3'd6, way: 2'd1, expDataWe: 1'b0};
        hitTable[4] = '{rd: 1'b0, wr: 1'b1, idx: 3'd2, way: 2'd2, expDataWe: 1'b1};

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        #1;
        checkIdleQuiet("rst");
        checkOutput("rst_victim", {30'd0, victim_way}, 32'd0);
        checkOutput("rst_mru",    {30'd0, lru_mru},    32'd0);
        checkOutput("rst_hitcnt", hit_count,           32'd0);
        checkOutput("rst_misscnt", miss_count,         32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // ---------------- Reset in the middle of a FILL ----------------
        tick();
        applyStimulus(1'b1, 1'b0, 3'd4, 1'b1, 2'd0, 1'b0, 2'd2, 1'b0);
        #1 hit = 1'b0;
        tick();
        #1 checkOutput("rf_check_noresp", {31'd0, cpu_resp}, 32'd0);
        tick();
        hit = 1'b1;
        #1 checkOutput("rf_memrd_before", {31'd0, mem_read}, 32'd1);
        #1 rst_n = 1'b0;
        #1 checkOutput("rf_memrd_async", {31'd0, mem_read}, 32'd0);
        checkOutput("rf_fillwe_async", {31'd0, fill_we}, 32'd0);
        checkOutput("rf_victim_async", {30'd0, victim_way}, 32'd0);
        cpu_read = 1'b0;
        mem_resp = 1'b1;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1 checkIdleQuiet("rf_after");
        end
        mem_resp  = 1'b0;
        expHits   = 0;
        expMisses = 0;

        // ---------------- Table-driven hits ----------------
        for (int i = 0; i < 5; i++) begin
            tick();
            applyStimulus(hitTable[i].rd, hitTable[i].wr, hitTable[i].idx,
                          1'b1, hitTable[i].way, 1'b0, 2'd0, 1'b0);
            #1 checkOutput($sformatf("hit%0d_idle_resp", i), {31'd0, cpu_resp}, 32'd0);
            checkOutput($sformatf("hit%0d_index", i), {29'd0, lru_index}, {29'd0, hitTable[i].idx});
            tick();
            #1;
            checkOutput($sformatf("hit%0d_resp", i),   {31'd0, cpu_resp},  32'd1);
            checkOutput($sformatf("hit%0d_load", i),   {31'd0, lru_load},  32'd1);
            checkOutput($sformatf("hit%0d_mru", i),    {30'd0, lru_mru},   {30'd0, hitTable[i].way});
            checkOutput($sformatf("hit%0d_datawe", i), {31'd0, data_we},   {31'd0, hitTable[i].expDataWe});
            checkOutput($sformatf("hit%0d_memrd", i),  {31'd0, mem_read},  32'd0);
            checkOutput($sformatf("hit%0d_memwr", i),  {31'd0, mem_write}, 32'd0);
            expHits++;
            tick();
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
            #1 checkOutput($sformatf("hit%0d_after_resp", i), {31'd0, cpu_resp}, 32'd0);
        end

        // ---------------- Spurious mem_resp in IDLE ----------------
        tick();
        mem_resp = 1'b1;
        hit      = 1'b1;
        #1 checkIdleQuiet("spur_idle");
        tick();
        #1 checkIdleQuiet("spur_next");
        mem_resp = 1'b0;

        // ---------------- Clean read miss, 4-cycle fill ----------------
        tick();
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b0);
        tick();
        #1 checkOutput("cm_check_resp", {31'd0, cpu_resp}, 32'd0);
        checkOutput("cm_check_load", {31'd0, lru_load}, 32'd0);
        checkOutput("cm_check_memrd", {31'd0, mem_read}, 32'd0);
        expMisses++;
        for (int k = 0; k < 4; k++) begin
            tick();
            lru_way  = 2'd3;
            mem_resp = (k == 3);
            #1;
            checkOutput($sformatf("cm_fill%0d_memrd", k), {31'd0, mem_read}, 32'd1);
            checkOutput($sformatf("cm_fill%0d_fillwe", k), {31'd0, fill_we}, (k == 3) ? 32'd1 : 32'd0);
            checkOutput($sformatf("cm_fill%0d_victim", k), {30'd0, victim_way}, 32'd1);
            checkOutput($sformatf("cm_fill%0d_resp", k), {31'd0, cpu_resp}, 32'd0);
        end
        tick();
        mem_resp = 1'b0;
        hit      = 1'b1;
        hit_way  = 2'd1;
        #1;
        checkOutput("cm_recheck_resp", {31'd0, cpu_resp}, 32'd1);
        checkOutput("cm_recheck_load", {31'd0, lru_load}, 32'd1);
        checkOutput("cm_recheck_mru",  {30'd0, lru_mru},  32'd1);
        checkOutput("cm_recheck_memrd", {31'd0, mem_read}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        #1 checkIdleQuiet("cm_done");

        // ---------------- Dirty write miss ----------------
        tick();
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
        tick();
        #1 checkOutput("dm_check_resp", {31'd0, cpu_resp}, 32'd0);
        checkOutput("dm_check_datawe", {31'd0, data_we}, 32'd0);
        expMisses++;
        for (int k = 0; k < 2; k++) begin
            tick();
            victim_dirty = 1'b0;
            mem_resp     = (k == 1);
            #1;
            checkOutput($sformatf("dm_wb%0d_memwr", k), {31'd0, mem_write}, 32'd1);
            checkOutput($sformatf("dm_wb%0d_memrd", k), {31'd0, mem_read}, 32'd0);
            checkOutput($sformatf("dm_wb%0d_victim", k), {30'd0, victim_way}, 32'd3);
            checkOutput($sformatf("dm_wb%0d_fillwe", k), {31'd0, fill_we}, 32'd0);
        end
        tick();
        mem_resp = 1'b1;
        #1;
        checkOutput("dm_fill_memwr",  {31'd0, mem_write}, 32'd0);
        checkOutput("dm_fill_memrd",  {31'd0, mem_read},  32'd1);
        checkOutput("dm_fill_fillwe", {31'd0, fill_we},   32'd1);
        tick();
        mem_resp = 1'b0;
        hit      = 1'b1;
        hit_way  = 2'd3;
        #1;
        checkOutput("dm_final_resp",   {31'd0, cpu_resp}, 32'd1);
        checkOutput("dm_final_datawe", {31'd0, data_we},  32'd1);
        checkOutput("dm_final_mru",    {30'd0, lru_mru},  32'd3);
        checkOutput("dm_final_index",  {29'd0, lru_index}, 32'd5);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        #1 checkIdleQuiet("dm_done");

        // ---------------- Performance counters ----------------
`ifdef CACHE_REPL_PERF_CNT_EN
        checkOutput("hit_count",  hit_count,  expHits);
        checkOutput("miss_count", miss_count, expMisses);
`else
        checkOutput("hit_count_tied",  hit_count,  32'd0);
        checkOutput("miss_count_tied", miss_count, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
